spi_frame_rx: RTL
=================

// Module: spi_frame_rx
// PURPOSE
//  SPI slave receiver in the clk domain. Oversamples sck/cs/mosi, assembles
//  WORD_W-bit words (cs active-low, MSB first, mosi sampled on sck rising), hunts
//  for a HEADER word, collects the NUM_CH following words and presents them as
//  one parallel sample vector with valid/ready. Sits between the board SPI pins
//  and the filter datapath inside top_all. Generalises the fixed 14-bit,
//  2-channel capture to any word width, channel count and header.
// PARAMETERS
//  WORD_W  14          bits per SPI word (one cs-low window = one word)
//  NUM_CH  2           data words collected after each header
//  HEADER  14'h0FFF    header word value, WORD_W bits wide
// PORTS
//  clk       in   1               system clock, rising edge
//  rstn      in   1               asynchronous active-low reset
//  sck       in   1               SPI clock, asynchronous to clk
//  mosi      in   1               SPI data in
//  cs        in   1               SPI chip select, active low
//  miso      out  1               SPI data out (see CONFIGURATION)
//  ch_data   out  NUM_CH*WORD_W   ch k at [k*WORD_W +: WORD_W]; ch0 = first word after header
//  ch_valid  out  1               ch_data valid, held until accepted
//  ch_ready  in   1               consumer accepts when ch_valid & ch_ready
//  frame_err out  1               one-cycle error pulse
// BEHAVIOUR
//  - Reset (async, rstn=0): ch_data=0, ch_valid=0, frame_err=0, miso=0, state=HUNT.
//    Sync regs reset to sck=0, cs=1, mosi=0. If cs is low when rstn rises, this
//    counts as a cs falling edge and starts a word.
//  - Sync: 2-FF synchroniser per input. Edges are detected on the synced signals.
//    Requirement: sck high and low times are each >= 3 clk periods.
//  - cs fall: clear shift reg and bit_cnt.
//  - sck rise while cs low: shift mosi in at the LSB, bit_cnt++ (saturates at WORD_W+1).
//  - cs rise with bit_cnt==WORD_W: one-cycle internal word_done with the word.
//  - cs rise with bit_cnt!=WORD_W: frame_err pulse, state -> HUNT, partial slots discarded.
//  - Latency: registered word_done occurs 3 clk edges after cs rises at the pin.
//  - FSM:
//    HUNT:    word_done & word==HEADER -> COLLECT, idx=0. Any other word is ignored, no error.
//    COLLECT: word_done -> slot[idx]=word. If idx==NUM_CH-1, move slots to ch_data,
//             ch_valid=1, -> HOLD; otherwise idx++. A HEADER value here is data, not resync.
//    HOLD:    ch_valid=1 and ch_data stable. ch_valid&ch_ready -> ch_valid=0, -> HUNT.
//             word_done in HOLD without a same-cycle handshake -> word dropped,
//             frame_err pulse (overrun), stay in HOLD.
//  - Handshake and word_done in the same cycle: the handshake completes and the word
//    is evaluated as in HUNT (a HEADER word moves directly to COLLECT).
//  - ch_valid rises 4 clk edges after the last data word's cs rises at the pin.
//  - ch_data changes only on the COLLECT->HOLD transfer.
//  - Reset mid-frame: all state returns to reset values. A partial word never completes.
// CONFIGURATION
//  MISO_ECHO_EN defined:
//    - On each cs fall, tx_shift loads last_word (the most recent word_done value,
//      reset 0).
//    - miso = tx_shift[WORD_W-1] while cs is low, 0 while cs is high.
//    - On each synced sck fall, tx_shift shifts left by 1 (zero fill), so the master
//      reads the previous word MSB first on sck rising.
//  MISO_ECHO_EN undefined: miso tied 0, no tx_shift or last_word logic.
// TESTING (clk 100 ns, sck half-period 81.92 us, cs guard 163.8 us)
//  1 rstn pulse low with cs held low -> ch_valid=0, frame_err=0, miso=0, ch_data=0;
//    a frame sent immediately afterwards is still received correctly.
//  2 words 0x0FFF, 0x054B, 0x054C -> ch_valid=1 exactly 4 clk after the final cs rise;
//    ch_data[13:0]=0x054B, ch_data[27:14]=0x054C; holds while ch_ready=0;
//    drops 1 cycle after ch_ready=1.
//  3 word 0x1234, then frame 0x0FFF, 0x055F, 0x0560 -> single ch_valid with
//    {0x0560, 0x055F}; frame_err never asserts.
//  4 0x0FFF, then a 10-bit word (cs rises early) -> one-cycle frame_err, no ch_valid;
//    a following full frame is received normally.
//  5 ch_ready=0 after a valid frame, second frame 0x0FFF, 0x0573, 0x0574 sent ->
//    3 frame_err pulses; ch_data keeps the first frame's values.
//  6 [MISO_ECHO_EN] send 0x054B, then any word -> miso bits sampled on sck rise
//    during the second word = 0x054B MSB first; miso=0 while cs=1.

Source files
------------

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: hunts for a HEADER word, then gathers NUM_CH data words into ch_data.
// Optional MISO_ECHO_EN: while cs is low, miso returns the previously received word, MSB first.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  HUNT    | waiting for a complete word equal to HEADER
//  COLLECT | storing data words into slot[idx]
//  HOLD    | ch_valid high with ch_data stable until ch_valid & ch_ready
`timescale 1ns/1ps
module spi_frame_rx #(
    parameter int                WORD_W = 14,
    parameter int                NUM_CH = 2,
    parameter logic [WORD_W-1:0] HEADER = 14'h0FFF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sck,
    input  logic                     mosi,
    input  logic                     cs,
    output logic                     miso,
    output logic [NUM_CH*WORD_W-1:0] ch_data,
    output logic                     ch_valid,
    input  logic                     ch_ready,
    output logic                     frame_err
);
    localparam int CNT_W = $clog2(WORD_W + 2);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {HUNT, COLLECT, HOLD} state_t;

    logic [1:0]        sck_sy, cs_sy, mosi_sy;
    logic              sck_q, cs_q;
    logic              sck_rise, cs_fall, cs_rise;
    logic [WORD_W-1:0] shift_reg, word_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done, len_err;

    state_t                     state, state_d;
    logic [IDX_W-1:0]           idx, idx_d;
    logic [NUM_CH*WORD_W-1:0]   slots, slots_d, data_d;
    logic                       valid_d, err_d, handshake;

    // Sync flops reset to the idle bus level so that cs already low at reset release reads as a fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sy  <= 2'b00;
            cs_sy   <= 2'b11;
            mosi_sy <= 2'b00;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            sck_sy  <= {sck_sy[0], sck};
            cs_sy   <= {cs_sy[0], cs};
            mosi_sy <= {mosi_sy[0], mosi};
            sck_q   <= sck_sy[1];
            cs_q    <= cs_sy[1];
        end
    end

    assign sck_rise = sck_sy[1] & ~sck_q;
    assign cs_fall  = ~cs_sy[1] & cs_q;
    assign cs_rise  = cs_sy[1] & ~cs_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_q    <= '0;
            word_done <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            word_done <= cs_rise && (bit_cnt == CNT_W'(WORD_W));
            len_err   <= cs_rise && (bit_cnt != CNT_W'(WORD_W));
            if (cs_rise)
                word_q <= shift_reg;
            if (cs_fall) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (sck_rise && !cs_sy[1]) begin
                shift_reg <= {shift_reg[WORD_W-2:0], mosi_sy[1]};
                if (bit_cnt != CNT_W'(WORD_W + 1))
                    bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HUNT;
            idx       <= '0;
            slots     <= '0;
            ch_data   <= '0;
            ch_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            slots     <= slots_d;
            ch_data   <= data_d;
            ch_valid  <= valid_d;
            frame_err <= err_d;
        end
    end

    assign handshake = ch_valid & ch_ready;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        slots_d = slots;
        data_d  = ch_data;
        valid_d = ch_valid;
        err_d   = 1'b0;
        case (state)
            HUNT: begin
                if (len_err)
                    err_d = 1'b1;
                else if (word_done && word_q == HEADER) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                end
            end
            COLLECT: begin
                if (len_err) begin
                    err_d   = 1'b1;
                    state_d = HUNT;
                    idx_d   = '0;
                end else if (word_done) begin
                    slots_d[int'(idx)*WORD_W +: WORD_W] = word_q;
                    if (idx == IDX_W'(NUM_CH - 1)) begin
                        data_d  = slots_d;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                // A bad word while holding flags an error but keeps the pending frame until accepted.
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = HUNT;
                    if (len_err)
                        err_d = 1'b1;
                    else if (word_done && word_q == HEADER) begin
                        state_d = COLLECT;
                        idx_d   = '0;
                    end
                end else if (word_done || len_err) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

`ifdef MISO_ECHO_EN
    logic [WORD_W-1:0] last_word, tx_shift;
    logic              sck_fall;

    assign sck_fall = ~sck_sy[1] & sck_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_word <= '0;
            tx_shift  <= '0;
        end else begin
            if (word_done)
                last_word <= word_q;
            if (cs_fall)
                tx_shift <= last_word;
            else if (sck_fall && !cs_sy[1])
                tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        end
    end

    assign miso = ~cs_sy[1] & tx_shift[WORD_W-1];
`else
    assign miso = 1'b0;
`endif

endmodule
